weight_tile_streamer: RTL and testbench

WEIGHT_TILE_STREAMER -- requirements
Module: weight_tile_streamer

---
 rtl/weight_tile_streamer_pkg.sv | 18 +
 rtl/weight_tile_streamer_pingpong_buffer.sv | 63 ++++++
 rtl/weight_tile_streamer.sv | 151 +++++++++++++++
 tb/tb_weight_tile_streamer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_tile_streamer_pkg.sv
// Shared accelerator definitions for the weight tile streamer: default widths,
// the tile array type and the run-control state encoding.
package weight_tile_streamer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_TILE_SIZE  = 32;
    localparam int DIM_WIDTH          = 10;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] tile_t [0:DEFAULT_TILE_SIZE-1];

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } stream_state_t;

endpackage

// File: rtl/weight_tile_streamer_pingpong_buffer.sv
// Two tile-sized banks: one is filled element by element while the other is
// offered downstream; per-bank full flags arbitrate ownership.
module tile_pingpong_buffer
    import weight_tile_streamer_pkg::*;
#(
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  TILE_SIZE  = DEFAULT_TILE_SIZE,
    localparam int IDX_WIDTH  = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [IDX_WIDTH-1:0]         wr_idx,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic                         wr_last,
    input  logic                         rd_pop,
    output logic [1:0]                   full,
    output logic                         rd_sel,
    output logic signed [DATA_WIDTH-1:0] rd_tile [0:TILE_SIZE-1]
);

    logic signed [DATA_WIDTH-1:0] bank [0:1][0:TILE_SIZE-1];
    logic                         wr_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the banks are reset (not left undefined) because the offered tile must read all-zero out of reset.
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < TILE_SIZE; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else if (wr_en) begin
            bank[wr_sel][wr_idx] <= wr_data;
        end
    end

    // A bank being written is never full, so a completing write and a pop never target the same flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flag update sees the pre-edge values of the others.
            if (wr_en && wr_last) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= ~wr_sel;
            end
            if (rd_pop) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < TILE_SIZE; i++) begin
            rd_tile[i] = bank[rd_sel][i];
        end
    end

endmodule

// File: rtl/weight_tile_streamer.sv
// Streams a rows x cols weight matrix from element-addressed memory as
// zero-padded TILE_SIZE tiles, row-major, through a ping-pong tile buffer.
module weight_tile_streamer
    import weight_tile_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TILE_SIZE  = DEFAULT_TILE_SIZE,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [DIM_WIDTH-1:0]         rows,
    input  logic [DIM_WIDTH-1:0]         cols,
    output logic                         busy,
    output logic                         done,
    output logic                         mem_rd_en,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic signed [DATA_WIDTH-1:0] mem_rdata,
    output logic                         w_valid,
    input  logic                         w_ready,
    output logic signed [DATA_WIDTH-1:0] w_tile_out [0:TILE_SIZE-1]
);

    localparam int IDX_WIDTH = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam int COL_WIDTH = $clog2((1 << DIM_WIDTH) + TILE_SIZE);

    stream_state_t state, state_nxt;

    logic [DIM_WIDTH-1:0] rows_q, cols_q, row_cnt;
    logic [COL_WIDTH-1:0] col_cnt;
    logic [IDX_WIDTH-1:0] elem_idx;
    logic                 iss_sel;

    // One-cycle slot pipeline aligning each slot with its read data.
    logic                 p_valid, p_pad, p_last;
    logic [IDX_WIDTH-1:0] p_idx;

    logic                         just_xfer, running, issue_ok, slot_is_read;
    logic                         tile_end, row_end, last_slot;
    logic [1:0]                   buf_full;
    logic                         buf_rd_sel;
    logic signed [DATA_WIDTH-1:0] fill_data;

    assign running = (state == S_FETCH) || (state == S_DRAIN);

    // The cycle after a transfer is always blank, even if the other bank is ready.
    assign w_valid = running && w_ready && buf_full[buf_rd_sel] && !just_xfer;

    // A slot may target the bank being popped this very cycle.
    assign issue_ok     = (state == S_FETCH) &&
                          (!buf_full[iss_sel] || (w_valid && (buf_rd_sel == iss_sel)));
    assign slot_is_read = col_cnt < COL_WIDTH'(cols_q);
    assign tile_end     = elem_idx == IDX_WIDTH'(TILE_SIZE - 1);
    assign row_end      = tile_end && ((col_cnt + COL_WIDTH'(1)) >= COL_WIDTH'(cols_q));
    assign last_slot    = row_end && (row_cnt == rows_q - DIM_WIDTH'(1));
    assign mem_rd_en    = issue_ok && slot_is_read;
    assign fill_data    = p_pad ? '0 : mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (rows == '0 || cols == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                busy = 1'b1;
                if (issue_ok && last_slot) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_valid && !p_valid && !buf_full[~buf_rd_sel]) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rows_q    <= '0;
            cols_q    <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            elem_idx  <= '0;
            iss_sel   <= 1'b0;
            mem_addr  <= '0;
            p_valid   <= 1'b0;
            p_pad     <= 1'b0;
            p_last    <= 1'b0;
            p_idx     <= '0;
            just_xfer <= 1'b0;
        end else begin
            just_xfer <= w_valid;
            p_valid   <= 1'b0;
            if (state == S_IDLE && start) begin
                rows_q   <= rows;
                cols_q   <= cols;
                mem_addr <= base_addr;
                row_cnt  <= '0;
                col_cnt  <= '0;
                elem_idx <= '0;
            end
            if (issue_ok) begin
                p_valid <= 1'b1;
                p_pad   <= !slot_is_read;
                p_idx   <= elem_idx;
                p_last  <= tile_end;
                if (slot_is_read) mem_addr <= mem_addr + ADDR_WIDTH'(1);
                if (tile_end)     iss_sel  <= ~iss_sel;
                if (row_end) begin
                    col_cnt  <= '0;
                    elem_idx <= '0;
                    row_cnt  <= row_cnt + DIM_WIDTH'(1);
                end else begin
                    col_cnt  <= col_cnt + COL_WIDTH'(1);
                    elem_idx <= tile_end ? '0 : elem_idx + IDX_WIDTH'(1);
                end
            end
        end
    end

    tile_pingpong_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .TILE_SIZE  (TILE_SIZE)
    ) u_pingpong (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (p_valid),
        .wr_idx  (p_idx),
        .wr_data (fill_data),
        .wr_last (p_last),
        .rd_pop  (w_valid),
        .full    (buf_full),
        .rd_sel  (buf_rd_sel),
        .rd_tile (w_tile_out)
    );

endmodule

// File: tb/tb_weight_tile_streamer.sv
// Directed and randomized runs of weight_tile_streamer scored against a
// row-major tiling model built from plain address arithmetic.
module tb_weight_tile_streamer;
    import weight_tile_streamer_pkg::*;

    localparam int DW        = DEFAULT_DATA_WIDTH;
    localparam int TS        = DEFAULT_TILE_SIZE;
    localparam int AW        = 16;
    localparam int TILE_BITS = DW * TS;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [DIM_WIDTH-1:0] rows, cols;
    logic                 busy, done, mem_rd_en, w_valid, w_ready;
    logic [AW-1:0]        mem_addr;
    logic signed [DW-1:0] mem_rdata = '0;
    tile_t                w_tile_out;

    always #5 clk = ~clk;

    weight_tile_streamer #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .rows       (rows),
        .cols       (cols),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_tile_out (w_tile_out)
    );

    logic [DW-1:0]        mem_model [0:(1<<AW)-1];
    logic [TILE_BITS-1:0] exp_tiles[$], got_tiles[$];
    logic [AW-1:0]        exp_addrs[$], got_addrs[$];

    int vectors = 0, miscompares = 0;
    int cycle_no = 0;
    int done_cnt, valid_cnt, xfer_cnt, proto_err;
    int done_cyc, last_xfer_cyc, first_valid_cyc;
    bit xfer_flag, prev_xfer;

    // Memory with one cycle of read latency.
    always @(posedge clk) begin
        cycle_no <= cycle_no + 1;
        if (mem_rd_en) mem_rdata <= mem_model[mem_addr];
    end

    function automatic logic [TILE_BITS-1:0] pack_tile(input tile_t t);
        logic [TILE_BITS-1:0] v;
        for (int i = 0; i < TS; i++) v[i*DW +: DW] = t[i];
        return v;
    endfunction

    // Observe on the falling edge, between input changes and the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_rd_en) got_addrs.push_back(mem_addr);
            if (w_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cycle_no;
                if (!w_ready) proto_err++;
                if (prev_xfer) proto_err++;
            end
            if (w_valid && w_ready) begin
                got_tiles.push_back(pack_tile(w_tile_out));
                xfer_cnt++;
                xfer_flag     = 1'b1;
                last_xfer_cyc = cycle_no;
            end
            prev_xfer = w_valid && w_ready;
            if (done) begin
                done_cnt++;
                done_cyc = cycle_no;
                if (busy) proto_err++;
            end
        end
    end

    task automatic check(input string tag, input logic [TILE_BITS-1:0] observed,
                         input logic [TILE_BITS-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < (1 << AW); i++) begin
            case (mode)
                0:       mem_model[i] = DW'(i);
                1:       mem_model[i] = DW'(i + 1);
                default: mem_model[i] = DW'($urandom);
            endcase
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // mode: 0 ready high, 1 random ready, 2 windowed consumer, 3 ready low for `hold` cycles.
    task automatic run_case(input string name, input logic [AW-1:0] base, input int r,
                            input int c, input int mode, input int hold);
        int  ntiles, tile_no, stall_reads, cyc, limit, start_cyc, gap, windows;
        bit  inject, after_xfer;
        ntiles      = (c + TS - 1) / TS;
        tile_no     = 0;
        stall_reads = 0;
        exp_tiles.delete(); exp_addrs.delete(); got_tiles.delete(); got_addrs.delete();
        for (int rr = 0; rr < r; rr++) begin
            for (int cc = 0; cc < c; cc++) exp_addrs.push_back(AW'(base + rr * c + cc));
            for (int t = 0; t < ntiles; t++) begin
                logic [TILE_BITS-1:0] v = '0;
                for (int i = 0; i < TS; i++) begin
                    if (t * TS + i < c) begin
                        v[i*DW +: DW] = mem_model[AW'(base + rr * c + t * TS + i)];
                        if (tile_no < 2) stall_reads++;
                    end
                end
                exp_tiles.push_back(v);
                tile_no++;
            end
        end
        done_cnt = 0; valid_cnt = 0; xfer_cnt = 0; proto_err = 0;
        done_cyc = -1; last_xfer_cyc = -1; first_valid_cyc = -1;
        xfer_flag = 1'b0; prev_xfer = 1'b0;
        windows = 0; gap = 1; after_xfer = 1'b0;
        inject  = (mode == 0) && (r * c >= 64);
        limit   = 500 + hold + 8 * r * ntiles * TS;

        @(posedge clk); #1;
        start = 1'b1; base_addr = base; rows = DIM_WIDTH'(r); cols = DIM_WIDTH'(c);
        w_ready   = (mode == 0);
        start_cyc = cycle_no;
        cyc = 0;
        while (done_cnt == 0 && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1 || cyc == 4) start = 1'b0;
            if (inject && cyc == 3) begin
                start = 1'b1; base_addr = 16'h1234; rows = 10'd7; cols = 10'd7;
            end
            case (mode)
                1: w_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (xfer_flag) begin
                        xfer_flag  = 1'b0;
                        after_xfer = 1'b1;
                    end else if (after_xfer) begin
                        after_xfer = 1'b0;
                        w_ready    = 1'b0;
                        gap        = $urandom_range(1, 4);
                    end else if (!w_ready) begin
                        if (gap > 0) gap--;
                        else begin
                            w_ready = 1'b1;
                            windows++;
                        end
                    end
                end
                3: begin
                    if (cyc == hold) begin
                        check({name, ".stall_reads"}, got_addrs.size(), stall_reads);
                        check({name, ".stall_no_valid"}, valid_cnt, 0);
                        w_ready = 1'b1;
                    end
                end
                default: w_ready = 1'b1;
            endcase
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({name, ".done_pulses"}, done_cnt, 1);
        check({name, ".read_count"}, got_addrs.size(), exp_addrs.size());
        for (int i = 0; i < exp_addrs.size() && i < got_addrs.size(); i++)
            check($sformatf("%s.addr%0d", name, i), got_addrs[i], exp_addrs[i]);
        check({name, ".tile_count"}, got_tiles.size(), exp_tiles.size());
        for (int i = 0; i < exp_tiles.size() && i < got_tiles.size(); i++)
            check($sformatf("%s.tile%0d", name, i), got_tiles[i], exp_tiles[i]);
        check({name, ".protocol"}, proto_err, 0);
        if (r > 0 && c > 0) begin
            check({name, ".done_after_last_xfer"}, done_cyc, last_xfer_cyc + 1);
            if (mode == 0)
                check({name, ".first_tile_latency"}, (first_valid_cyc - start_cyc) <= TS + 4, 1);
        end else begin
            check({name, ".empty_done_cycle"}, done_cyc, start_cyc + 1);
            check({name, ".empty_no_valid"}, valid_cnt, 0);
        end
        if (mode == 2) check({name, ".one_xfer_per_window"}, xfer_cnt, windows);
        if (done_cnt == 0) apply_reset();
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = '0; rows = '0; cols = '0; w_ready = 1'b0;
        #3;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.mem_rd_en", mem_rd_en, 0);
        check("rst.w_valid", w_valid, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.tile", pack_tile(w_tile_out), 0);
        @(posedge clk); #1 reset_n = 1'b1;

        fill_mem(0); run_case("two_full_tiles", 16'h0000, 2, 32, 0, 0);
        fill_mem(1); run_case("padded_row", 16'h0000, 1, 40, 0, 0);
        fill_mem(0); run_case("backpressure", 16'h0000, 4, 64, 3, 200);
        fill_mem(2); run_case("window_consumer", AW'($urandom), 3, 50, 2, 0);
        run_case("zero_rows", 16'h0100, 0, 10, 0, 0);
        run_case("zero_cols", 16'h0100, 5, 0, 0, 0);
        fill_mem(2); run_case("addr_wrap", 16'hFFFE, 1, 4, 0, 0);

        // Reset in the middle of a fetch, then a clean run.
        fill_mem(0);
        @(posedge clk); #1;
        start = 1'b1; base_addr = '0; rows = 10'd3; cols = 10'd64; w_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midrst.busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midrst.busy", busy, 0);
        check("midrst.done", done, 0);
        check("midrst.mem_rd_en", mem_rd_en, 0);
        check("midrst.w_valid", w_valid, 0);
        check("midrst.mem_addr", mem_addr, 0);
        check("midrst.tile", pack_tile(w_tile_out), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        run_case("post_reset", 16'h0000, 1, 32, 0, 0);

        for (int k = 0; k < 4; k++) begin
            fill_mem(2);
            run_case($sformatf("random%0d", k), AW'($urandom), $urandom_range(1, 3),
                     $urandom_range(1, 70), 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
